binary_to_bcd_converter__4: RTL and testbench



---
 rtl/binary_to_bcd_converter__4.sv | 105 ++++++++++
 tb/tb_binary_to_bcd_converter__4.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_converter__4.sv
// Sequential double-dabble binary-to-BCD converter: one shift/add-3 step per clock.
// Optional build macro BCD_SATURATE_EN clamps the BCD output to 9999 on overflow.
module binary_to_bcd_converter__4 #(
  parameter int BINARY_WIDTH     = 16,
  parameter int NUMBER_OF_DIGITS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [BINARY_WIDTH-1:0]       in_binary,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [4*NUMBER_OF_DIGITS-1:0] bcd,
  output logic                          overflow,
  output logic                          out_valid
);

  localparam int ACC_W = 20;
  localparam int BCD_W = 4 * NUMBER_OF_DIGITS;
  localparam int SR_W  = ACC_W + BINARY_WIDTH;
  localparam logic [4:0] LAST_STEP = 5'(BINARY_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [SR_W-1:0]   sr_q;
  logic [BCD_W-1:0]  bcd_q;
  logic              overflow_q;
  logic              out_valid_q;

  logic [ACC_W-1:0]  acc_adj;
  logic [SR_W-1:0]   sr_d;
  logic [ACC_W-1:0]  acc_d;
  logic              overflow_d;
  logic [BCD_W-1:0]  bcd_d;

  // One double-dabble step: add 3 to every digit >= 5, then shift the whole register left.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_adj = sr_q[SR_W-1 -: ACC_W];
    for (int d = 0; d < ACC_W / 4; d++) begin
      if (acc_adj[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_adj[4*d +: 4] + 4'd3;
      end
    end
    sr_d       = {acc_adj, sr_q[BINARY_WIDTH-1:0]} << 1;
    acc_d      = sr_d[SR_W-1 -: ACC_W];
    overflow_d = |acc_d[ACC_W-1:BCD_W];
`ifdef BCD_SATURATE_EN
    bcd_d = overflow_d ? {NUMBER_OF_DIGITS{4'h9}} : acc_d[BCD_W-1:0];
`else
    bcd_d = acc_d[BCD_W-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            state_q     <= DONE;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the shift register is pure datapath, always loaded on accept before use, so it has no reset.
  always_ff @(posedge clock) begin
    if (state_q == IDLE && in_valid) begin
      sr_q <= {{ACC_W{1'b0}}, in_binary};
    end else if (state_q == SHIFT) begin
      sr_q <= sr_d;
    end
  end

  // Gated by reset_n so the source sees "not ready" for as long as reset is held.
  assign in_ready  = reset_n && (state_q == IDLE);
  assign bcd       = bcd_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_to_bcd_converter__4.sv
// Directed bench for binary_to_bcd_converter__4: vector table plus handshake, hold and reset sequences.
// Honours BCD_SATURATE_EN when computing expected BCD for overflowing inputs.
module tb_binary_to_bcd_converter__4;

  logic        clock;
  logic        reset_n;
  logic [15:0] in_binary;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        overflow;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] bin;
    logic [15:0] low;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  binary_to_bcd_converter__4 #(
    .BINARY_WIDTH    (16),
    .NUMBER_OF_DIGITS(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_binary(in_binary),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd      (bcd),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_bcd(input logic [15:0] low, input logic ovf);
`ifdef BCD_SATURATE_EN
    return ovf ? 16'h9999 : low;
`else
    return (ovf === 1'b1) ? low : low;
`endif
  endfunction

  // Called mid-cycle: presents val, expects accept at the next edge (k) and the result at k+16.
  task automatic run_conv(input string name, input logic [15:0] val,
                          input logic [15:0] exp_b, input logic exp_o);
    logic [15:0] prev;
    int          early;
    prev  = bcd;
    early = 0;
    check({name, "_ready_before"}, 32'(in_ready), 32'd1);
    in_binary = val;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
    in_binary = ~val;
    check({name, "_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clock); #1;
      if (i < 16) begin
        early += int'(out_valid);
        if (i == 15) check({name, "_bcd_held"}, 32'(bcd), 32'(prev));
      end
    end
    check({name, "_early_pulse"}, 32'(early), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_bcd"}, 32'(bcd), 32'(exp_b));
    check({name, "_overflow"}, 32'(overflow), 32'(exp_o));
    check({name, "_ready_done"}, 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    check({name, "_pulse_end"}, 32'(out_valid), 32'd0);
    check({name, "_ready_after"}, 32'(in_ready), 32'd1);
    check({name, "_bcd_kept"}, 32'(bcd), 32'(exp_b));
  endtask

  initial begin
    int bad;
    int pulses;

    vecs[0] = '{"v1234",  16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{"v9999",  16'd9999,  16'h9999, 1'b0};
    vecs[2] = '{"v0",     16'd0,     16'h0000, 1'b0};
    vecs[3] = '{"v10000", 16'd10000, 16'h0000, 1'b1};
    vecs[4] = '{"v65535", 16'd65535, 16'h5535, 1'b1};
    vecs[5] = '{"v1",     16'd1,     16'h0001, 1'b0};
    vecs[6] = '{"v59",    16'd59,    16'h0059, 1'b0};
    vecs[7] = '{"v4095",  16'd4095,  16'h4095, 1'b0};
    vecs[8] = '{"v12345", 16'd12345, 16'h2345, 1'b1};
    vecs[9] = '{"v8080",  16'd8080,  16'h8080, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_binary = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    check("ready_in_reset", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    check("idle_no_pulse", 32'(out_valid), 32'd0);

    for (int v = 0; v < 10; v++) begin
      run_conv(vecs[v].name, vecs[v].bin, exp_bcd(vecs[v].low, vecs[v].ovf), vecs[v].ovf);
    end

    // in_valid held high with the value changing each cycle: accepts only at k and k+18.
    bad    = 0;
    pulses = 0;
    in_binary = 16'd42;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    for (int m = 1; m <= 35; m++) begin
      in_binary = 16'(7 + m);
      @(posedge clock); #1;
      pulses += int'(out_valid);
      if (out_valid !== ((m == 16) || (m == 34))) bad++;
      if (m == 16) check("hold_bcd_42", 32'(bcd), 32'h0042);
      if (m == 17) check("hold_ready_k17", 32'(in_ready), 32'd1);
      if (m == 18) check("hold_ready_k18", 32'(in_ready), 32'd0);
      if (m == 34) check("hold_bcd_25", 32'(bcd), 32'h0025);
    end
    in_valid = 1'b0;
    check("hold_pulse_positions", 32'(bad), 32'd0);
    check("hold_pulse_count", 32'(pulses), 32'd2);

    // Reset after 5 shift steps aborts the conversion of 500.
    pulses = 0;
    in_binary = 16'd500;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      pulses += int'(out_valid);
    end
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    pulses += int'(out_valid);
    check("abort_no_pulse", 32'(pulses), 32'd0);
    check("abort_bcd_zero", 32'(bcd), 32'h0);
    check("abort_ready_low", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("abort_ready_release", 32'(in_ready), 32'd1);
    run_conv("post_abort_77", 16'd77, 16'h0077, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
